// File: rtl/detector_uart_rx.sv
// detector_uart_rx: 8N1 UART receiver for a simulated obstacle-detector link.
// The rx line is synchronized, framed by a five-state FSM (IDLE, START, DATA,
// STOP, BREAK) and every correctly framed byte is presented on data with a
// one-cycle data_valid pulse. A byte whose upper nibble is 4'b1010 is a
// detector frame, and its lower nibble loads the four obstacle flags.
// A bad stop bit gives a one-cycle frame_err pulse. The receiver then waits
// in BREAK until the line returns high.
// Optional feature: define DETECTOR_TIMEOUT_EN to build the link-loss watchdog.
// When it is left undefined, link_lost is tied to 0.
// Handshake: data_valid is a strobe with no ready. data, data_valid and the
// detector flags change on the same clock edge, and no back-pressure exists.
// fsm_state exposes the FSM encoding for observation.
module detector_uart_rx #(
    parameter int CLK_FREQ       = 100000000,
    parameter int BAUD           = 9600,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       front_detector,
    output logic       back_detector,
    output logic       left_detector,
    output logic       right_detector,
    output logic       link_lost,
    output logic [2:0] fsm_state
);

    localparam int BIT_CYCLES = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int HALF       = BIT_CYCLES / 2;
    localparam int CW         = $clog2(BIT_CYCLES + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t        state, state_next;
    logic          rx_meta, rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic [3:0]    det;
    logic          cnt_clr, take_bit, frame_ok, frame_bad, det_frame;

    assign fsm_state      = state;
    assign front_detector = det[0];
    assign back_detector  = det[1];
    assign left_detector  = det[2];
    assign right_detector = det[3];

    // A detector frame is a good stop bit on a byte tagged 4'b1010.
    assign det_frame = frame_ok && (shift[7:4] == 4'b1010);

    // Two-flop synchronizer; reset to the idle-high line level.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // FSM state register.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic and per-cycle sampling strobes.
    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        take_bit   = 1'b0;
        frame_ok   = 1'b0;
        frame_bad  = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    cnt_clr    = 1'b1;
                end
            end
            START: begin
                // Mid-start-bit check: a high line here is a glitch.
                if (cnt == HALF_LAST) begin
                    cnt_clr    = 1'b1;
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_clr  = 1'b1;
                    take_bit = 1'b1;
                    if (bit_idx == 3'd7) state_next = STOP;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_clr = 1'b1;
                    if (rx_s) begin
                        frame_ok   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_bad  = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                // Hold off start detection until the line is released.
                if (rx_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Bit timer, bit index and LSB-first shift register.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
        end else begin
            if (cnt_clr)
                cnt <= '0;
            else if (state == START || state == DATA || state == STOP)
                cnt <= cnt + 1'b1;
            else
                cnt <= '0;

            if (state == START)
                bit_idx <= 3'd0;
            else if (take_bit)
                bit_idx <= bit_idx + 3'd1;

            if (take_bit)
                shift <= {rx_s, shift[7:1]};
        end
    end

    // Output registers: byte, strobes, detector flags and optional watchdog.
`ifdef DETECTOR_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [WW-1:0] WD_FULL = WW'(TIMEOUT_CYCLES);
    logic [WW-1:0] wd_cnt;
`endif

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            data       <= 8'h00;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            det        <= 4'h0;
            link_lost  <= 1'b0;
`ifdef DETECTOR_TIMEOUT_EN
            wd_cnt     <= '0;
`endif
        end else begin
            data_valid <= frame_ok;
            frame_err  <= frame_bad;
            if (frame_ok) data <= shift;
`ifdef DETECTOR_TIMEOUT_EN
            if (det_frame) begin
                det       <= shift[3:0];
                wd_cnt    <= '0;
                link_lost <= 1'b0;
            end else if (wd_cnt == WD_LAST) begin
                // Silence for the whole window: assume obstacles everywhere.
                wd_cnt    <= WD_FULL;
                link_lost <= 1'b1;
                det       <= 4'hF;
            end else if (wd_cnt != WD_FULL) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
`else
            link_lost <= 1'b0;
            if (det_frame) det <= shift[3:0];
`endif
        end
    end

endmodule
